// File: rtl/uart_reg_ctrl_pkg.sv
// rtl/uart_reg_ctrl_pkg.sv - shared state encoding, opcodes and response bytes for uart_reg_ctrl
package uart_reg_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_REG_WR   = 3'd3;
    localparam logic [2:0] ST_REG_RD   = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_SEND     = 3'd6;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/uart_reg_ctrl.sv
// rtl/uart_reg_ctrl.sv - uart FIFO command frames to 8-bit register bus sequencer (optional UART_CTRL_TIMEOUT_EN)
module uart_reg_ctrl
    import uart_reg_ctrl_pkg::*;
#(
    parameter int AW     = 8,
    parameter int TO_CYC = 500000,
    parameter int TO_W   = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    input  logic          tx_full,
    output logic [7:0]    w_data,
    output logic          wr_uart,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_wr,
    output logic          reg_rd,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          frame_err
);

    logic [2:0]    state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rsp_q, rsp_d;
    logic          accepting;
    logic          pop;
    logic          bad_op;
    logic          to_hit;

    // Gating with reset keeps every output at 0 while reset is held, even with rx bytes pending.
    assign accepting = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign pop       = reset && accepting && !rx_empty;
    assign bad_op    = pop && (state_q == ST_IDLE) && !is_opcode(r_data);

    assign rd_uart   = pop;
    assign wr_uart   = (state_q == ST_SEND) && !tx_full;
    assign w_data    = rsp_q;
    assign reg_wr    = (state_q == ST_REG_WR);
    assign reg_rd    = (state_q == ST_REG_RD);
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign frame_err = bad_op || to_hit;

`ifdef UART_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic            waiting;

    assign waiting = ((state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA)) && rx_empty;
    assign to_hit  = waiting && (to_cnt_q == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) || pop || to_hit) begin
            to_cnt_q <= '0;
        end else if (waiting) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_to_cfg;
    assign to_hit        = 1'b0;
    assign unused_to_cfg = ^{TO_CYC, TO_W};
`endif

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (is_opcode(r_data)) begin
                        op_wr_d = (r_data == OP_WR);
                        state_d = ST_GET_ADDR;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (pop) begin
                    addr_d  = r_data[AW-1:0];
                    state_d = op_wr_q ? ST_GET_DATA : ST_REG_RD;
                end else if (to_hit) begin
                    rsp_d   = RSP_ERR;
                    state_d = ST_SEND;
                end
            end
            ST_GET_DATA: begin
                if (pop) begin
                    wdata_d = r_data;
                    state_d = ST_REG_WR;
                end else if (to_hit) begin
                    rsp_d   = RSP_ERR;
                    state_d = ST_SEND;
                end
            end
            ST_REG_WR: begin
                rsp_d   = RSP_OK;
                state_d = ST_SEND;
            end
            ST_REG_RD:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                rsp_d   = reg_rdata;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_full) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb/tb_uart_reg_ctrl.sv - directed self-checking bench for uart_reg_ctrl
module tb_uart_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       frame_err;

    uart_reg_ctrl #(.AW(8), .TO_CYC(50), .TO_W(19)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] mem [256];
    int cyc = 0, pops = 0, last_pop = 0, tx_cyc = 0;
    int nwr = 0, nrd = 0, nerr = 0, wr_cyc = 0, rd_cyc = 0, overlap = 0, bad_pop = 0;
    logic [7:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
    int checks = 0, failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        rx_empty = (rx_q.size() == 0);
        r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (rd_uart) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            else bad_pop++;
            pops++;
            last_pop = cyc;
        end
        if (wr_uart) begin
            tx_q.push_back(w_data);
            tx_cyc = cyc;
        end
        if (reg_wr) begin
            nwr++; wr_addr = reg_addr; wr_data = reg_wdata; wr_cyc = cyc;
            mem[reg_addr] <= reg_wdata;
        end
        if (reg_rd) begin
            nrd++; rd_addr = reg_addr; rd_cyc = cyc;
            reg_rdata <= mem[reg_addr];
        end
        if (frame_err) nerr++;
        if ((reg_wr && reg_rd) || (wr_uart && rd_uart)) overlap++;
        cyc++;
    end

    task automatic wait_tx(input int n, input int limit, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk_eq(tag, tx_q.size(), n);
    endtask

    initial begin
        int b_wr, b_rd, b_err, b_pop, hi, nb;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h22] = 8'h3C;
        mem[8'h01] = 8'h5A;

        repeat (3) @(negedge clk);
        chk_eq("reset_strobes", {rd_uart, wr_uart, reg_wr, reg_rd, busy, frame_err}, 6'b0);
        chk_eq("reset_regs", {reg_addr, reg_wdata, w_data}, 24'h0);
        reset = 1'b1;
        @(negedge clk);

        // 1: write frame
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5);
        wait_tx(1, 30, "t1_tx_count");
        chk_eq("t1_nwr", nwr, 1);
        chk_eq("t1_wr_addr", wr_addr, 8'h10);
        chk_eq("t1_wr_data", wr_data, 8'hA5);
        chk_eq("t1_rsp", tx_q[0], 8'h4B);
        chk_eq("t1_wr_lat", wr_cyc - last_pop, 1);
        chk_eq("t1_tx_lat", tx_cyc - last_pop, 2);
        tx_q.delete();

        // 2: read frame
        rx_q.push_back(8'h52); rx_q.push_back(8'h22);
        wait_tx(1, 30, "t2_tx_count");
        chk_eq("t2_nrd", nrd, 1);
        chk_eq("t2_rd_addr", rd_addr, 8'h22);
        chk_eq("t2_rsp", tx_q[0], 8'h3C);
        chk_eq("t2_rd_lat", rd_cyc - last_pop, 1);
        chk_eq("t2_tx_lat", tx_cyc - last_pop, 3);
        tx_q.delete();

        // 3: bad opcode then normal read
        b_wr = nwr; b_rd = nrd; b_err = nerr;
        rx_q.push_back(8'h00); rx_q.push_back(8'h52); rx_q.push_back(8'h01);
        wait_tx(2, 40, "t3_tx_count");
        chk_eq("t3_err_rsp", tx_q[0], 8'h45);
        chk_eq("t3_rd_rsp", tx_q[1], 8'h5A);
        chk_eq("t3_frame_err", nerr - b_err, 1);
        chk_eq("t3_no_wr", nwr - b_wr, 0);
        chk_eq("t3_one_rd", nrd - b_rd, 1);
        tx_q.delete();

        // 4: tx back-pressure in SEND, with a second frame already queued
        tx_full = 1'b1;
        b_wr = nwr;
        rx_q.push_back(8'h57); rx_q.push_back(8'h33); rx_q.push_back(8'h77);
        rx_q.push_back(8'h52); rx_q.push_back(8'h33);
        for (int k = 0; k < 30 && nwr == b_wr; k++) @(negedge clk);
        chk_eq("t4_reached_wr", nwr - b_wr, 1);
        b_pop = pops; hi = 0; nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (wr_uart) hi++;
            if (!busy) nb++;
            @(negedge clk);
        end
        chk_eq("t4_wr_held", hi, 0);
        chk_eq("t4_busy", nb, 0);
        chk_eq("t4_no_pops", pops - b_pop, 0);
        chk_eq("t4_no_tx", tx_q.size(), 0);
        tx_full = 1'b0;
        wait_tx(2, 40, "t4_tx_count");
        chk_eq("t4_rsp_ok", tx_q[0], 8'h4B);
        chk_eq("t4_rsp_rd", tx_q[1], 8'h77);
        tx_q.delete();

        // 5: reset mid-frame
        b_wr = nwr; b_pop = pops;
        rx_q.push_back(8'h57); rx_q.push_back(8'h10);
        for (int k = 0; k < 20 && pops - b_pop < 2; k++) @(negedge clk);
        chk_eq("t5_pops", pops - b_pop, 2);
        reset = 1'b0;
        #1;
        chk_eq("t5_rst_strobes", {rd_uart, wr_uart, reg_wr, reg_rd, busy, frame_err}, 6'b0);
        chk_eq("t5_rst_regs", {reg_addr, reg_wdata, w_data}, 24'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        b_rd = nrd;
        rx_q.push_back(8'h52); rx_q.push_back(8'h10);
        wait_tx(1, 30, "t5_tx_count");
        chk_eq("t5_rsp", tx_q[0], 8'hA5);
        chk_eq("t5_no_wr", nwr - b_wr, 0);
        chk_eq("t5_one_rd", nrd - b_rd, 1);
        tx_q.delete();

        // 6: partial frame left hanging
        b_err = nerr; b_wr = nwr; b_rd = nrd;
        rx_q.push_back(8'h57);
`ifdef UART_CTRL_TIMEOUT_EN
        wait_tx(1, 100, "t6_tx_count");
        chk_eq("t6_rsp", tx_q[0], 8'h45);
        chk_eq("t6_lat", tx_cyc - last_pop, 51);
        chk_eq("t6_frame_err", nerr - b_err, 1);
`else
        repeat (1000) @(negedge clk);
        chk_eq("t6_no_tx", tx_q.size(), 0);
        chk_eq("t6_busy", busy, 1'b1);
        chk_eq("t6_no_err", nerr - b_err, 0);
`endif
        chk_eq("t6_no_strobe", (nwr - b_wr) + (nrd - b_rd), 0);

        chk_eq("overlap", overlap, 0);
        chk_eq("bad_pop", bad_pop, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
